// File: rtl/if1_fetch_aligner_if.sv
// Fetch-packet and instruction-buffer handshake between the I-cache response
// path, the fetch aligner and the IB.
interface if1_fetch_aligner_if #(
  parameter int unsigned FETCH_W = 4,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned FREE_W  = 4
);
  localparam int unsigned CNT_W = $clog2(FETCH_W) + 1;
  localparam int unsigned ENT_W = 2 + PC_W + INST_W;

  logic                      in_valid;
  logic                      in_ready;
  logic [PC_W-1:0]           in_pc;
  logic [FETCH_W-1:0]        in_pc_valid;
  logic [FETCH_W-1:0]        in_pc_jump;
  logic [FETCH_W*INST_W-1:0] in_rdata;
  logic [FREE_W-1:0]         ib_free;
  logic [CNT_W-1:0]          push_num;
  logic [FETCH_W*ENT_W-1:0]  ib_data;

  modport master (
    output in_valid, in_pc, in_pc_valid, in_pc_jump, in_rdata, ib_free,
    input  in_ready, push_num, ib_data
  );

  modport slave (
    input  in_valid, in_pc, in_pc_valid, in_pc_jump, in_rdata, ib_free,
    output in_ready, push_num, ib_data
  );
endinterface

// File: rtl/if1_fetch_aligner.sv
// Second fetch stage: aligns a fetch packet to its start slot, truncates after
// the first taken jump, and pushes into the IB with a skid buffer for overflow.
module if1_fetch_aligner #(
  parameter int unsigned FETCH_W       = 4,
  parameter int unsigned PC_W          = 32,
  parameter int unsigned INST_W        = 32,
  parameter int unsigned FREE_W        = 4,
  parameter bit          TRUNC_ON_JUMP = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  if1_fetch_aligner_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(FETCH_W);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned ENT_W = 2 + PC_W + INST_W;
  localparam int unsigned MIN_W = (CNT_W > FREE_W) ? CNT_W : FREE_W;

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e             state, state_n;
  logic [ENT_W-1:0]   held   [FETCH_W];
  logic [ENT_W-1:0]   held_n [FETCH_W];
  logic [CNT_W-1:0]   buf_cnt, buf_cnt_n;

  logic [IDX_W-1:0]   s;
  logic [IDX_W-1:0]   last;
  logic               found;
  logic [IDX_W-1:0]   slot;
  logic [CNT_W-1:0]   n_new;
  logic [CNT_W-1:0]   avail;
  logic [CNT_W-1:0]   push;
  logic [MIN_W-1:0]   avail_w, free_w;
  logic [PC_W-IDX_W-3:0] pc_hi;
  logic [ENT_W-1:0]   pkt [FETCH_W];
  logic [ENT_W-1:0]   src [FETCH_W];
  logic               unused_pc_lsb;

  assign s             = bus.in_pc[IDX_W+1:2];
  assign pc_hi         = bus.in_pc[PC_W-1:IDX_W+2];
  assign unused_pc_lsb = ^bus.in_pc[1:0];

  // Last surviving slot: the first valid taken jump at or after s, else the top slot.
  always_comb begin
    last  = '1;
    found = 1'b0;
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      if (TRUNC_ON_JUMP && !found && (IDX_W'(k) >= s) &&
          bus.in_pc_valid[k] && bus.in_pc_jump[k]) begin
        last  = IDX_W'(k);
        found = 1'b1;
      end
    end
    n_new = CNT_W'(last) - CNT_W'(s) + CNT_W'(1);
  end

  always_comb begin
    slot = '0;
    for (int unsigned j = 0; j < FETCH_W; j++) begin
      slot   = s + IDX_W'(j);
      pkt[j] = '0;
      if (CNT_W'(j) < n_new)
        pkt[j] = {bus.in_pc_valid[slot], bus.in_pc_jump[slot], pc_hi, slot, 2'b00,
                  bus.in_rdata[int'(slot)*INST_W +: INST_W]};
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < FETCH_W; k++)
      src[k] = (state == HOLD) ? held[k] : pkt[k];

    if (state == HOLD)     avail = buf_cnt;
    else if (bus.in_valid) avail = n_new;
    else                   avail = '0;

    avail_w = MIN_W'(avail);
    free_w  = MIN_W'(bus.ib_free);
    push    = flush ? '0 : ((avail_w < free_w) ? avail : CNT_W'(free_w));

    bus.push_num = push;
    bus.in_ready = (state == EMPTY) && !flush;
    bus.ib_data  = '0;
    for (int unsigned k = 0; k < FETCH_W; k++)
      if (CNT_W'(k) < avail) bus.ib_data[k*ENT_W +: ENT_W] = src[k];
  end

  // Held entries and a freshly accepted packet share one path: unpushed source
  // entries shift down by push. An unaccepted packet never reaches src in HOLD.
  always_comb begin
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      held_n[k] = '0;
      if (k + 32'(push) < FETCH_W) held_n[k] = src[k + 32'(push)];
    end
    buf_cnt_n = flush ? '0 : (avail - push);
    state_n   = (buf_cnt_n == '0) ? EMPTY : HOLD;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= EMPTY;
      buf_cnt <= '0;
      for (int unsigned k = 0; k < FETCH_W; k++) held[k] <= '0;
    end else begin
      state   <= state_n;
      buf_cnt <= buf_cnt_n;
      for (int unsigned k = 0; k < FETCH_W; k++) held[k] <= held_n[k];
    end
  end
endmodule
